lab_pattern_seq: RTL
====================

LAB_PATTERN_SEQ -- requirements
Module: lab_pattern_seq

Interface
REQ-001 Parameter SEL_W, default 2: width of the code selecting a pattern; the table holds 2**SEL_W entries.
REQ-002 Parameter OUT_W, default 4: width of each pattern entry.
REQ-003 Parameter DIV_W, default 8: width of the auto-step divider.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port sel  input  SEL_W  manual code select.
REQ-007 Port mode  input  1  0 = manual, 1 = auto-step.
REQ-008 Port hold  input  1  auto mode only: freezes the prescaler and the code.
REQ-009 Port div  input  DIV_W  auto step period minus one, in clk cycles.
REQ-010 Port wr_en  input  1  table write strobe.
REQ-011 Port wr_addr  input  SEL_W  table write address.
REQ-012 Port wr_data  input  OUT_W  table write data.
REQ-013 Port code_out  output  SEL_W  registered current code.
REQ-014 Port pattern_out  output  OUT_W  registered pattern for code_out.
REQ-015 Port step  output  1  one-cycle pulse on each auto increment.

Function
REQ-016 Table contents after reset SHALL be: entry0 = 0000, entry1 = 0011, entry2 = 1100, entry3 = 1001, each zero-extended or truncated (LSBs kept) to OUT_W; entries above 3 = 0.
REQ-017 Invariant, at every cycle after reset: pattern_out == table[code_out], using the table contents after any write at that edge.
REQ-018 Write on an edge with wr_en=1 SHALL update table[wr_addr]; when wr_addr equals the next code_out, pattern_out SHALL load wr_data at that same edge (write-through).
REQ-019 Manual mode (mode=0): at each edge, code_out <= sel and pattern_out <= table[sel]; latency is 1 cycle; the prescaler is held at 0; step = 0.
REQ-020 Auto mode (mode=1, hold=0): the prescaler increments each cycle; when prescaler >= div, code_out SHALL increment modulo 2**SEL_W (all-ones wraps to 0), pattern_out SHALL follow, step SHALL be 1 for that cycle and the prescaler SHALL clear to 0.
REQ-021 div=0 SHALL produce a step on every cycle.
REQ-022 Reducing div mid-count below the prescaler value SHALL cause a step at the next edge; there is no counter overflow path.
REQ-023 hold=1 in auto mode SHALL freeze the prescaler and code_out, and step SHALL be 0; table writes still take effect per REQ-018.
REQ-024 Manual-to-auto switch: counting SHALL start from the current code_out with prescaler 0; the first step comes div+1 cycles after mode rises.
REQ-025 Auto-to-manual switch: the prescaler SHALL clear, and code_out SHALL take sel at the first edge with mode=0.
REQ-026 Inputs SHALL be sampled only at the clk rising edge; step SHALL never be high for two cycles unless div=0.

Reset
REQ-027 While rst=1, regardless of clk: code_out = 0, pattern_out = 0, step = 0, prescaler = 0, and the table is at its REQ-016 defaults.
REQ-028 rst asserted mid-auto-count SHALL discard the prescaler and any writes; after release, the block resumes in the mode given by the inputs.

Verification
REQ-029 Reset table check: release rst, mode=0, sweep sel 0..3 -> pattern_out = 0000, 0011, 1100, 1001, each one cycle after its sel.
REQ-030 Manual latency: sel 0->2 at edge N -> code_out=2 and pattern_out=1100 after edge N, step=0 throughout.
REQ-031 Auto wrap: code_out=3, div=3, mode rises -> step on the 4th edge, code_out=0 and pattern_out=0000; next step 4 cycles later to code_out=1.
REQ-032 Write-through: auto, hold=1, code_out=1, wr_en with wr_addr=1 and wr_data=1010 -> pattern_out=1010 after the same edge; entry readback unchanged after release of hold.
REQ-033 Hold/div change: auto with div=9 and prescaler at 6; set hold=1 for 5 cycles -> no step; drop hold and set div=2 -> step at the next edge.
REQ-034 Async reset: assert rst between clk edges in auto mode with entry2 rewritten -> outputs go to 0 immediately (no clock edge needed), and the table returns to defaults (entry2 = 1100).

Source files
------------

// File: rtl/lab_pattern_seq.sv
// Pattern sequencer: a writable code->pattern table driven by a manual
// select or by an auto-stepping code counter with a programmable period.
// Outputs are registered (1-cycle latency); no flow control, every edge acts.
module lab_pattern_seq #(
   parameter int SEL_W = 2,
   parameter int OUT_W = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   input  logic             hold,
   input  logic [DIV_W-1:0] div,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [OUT_W-1:0] wr_data,
   output logic [SEL_W-1:0] code_out,
   output logic [OUT_W-1:0] pattern_out,
   output logic             step
);

   localparam int N_ENT = 1 << SEL_W;

   typedef logic [OUT_W-1:0] entry_t;

   // Operating mode decoded from the mode/hold inputs for this edge.
   typedef enum logic [1:0] {
      OP_MANUAL    = 2'd0,
      OP_AUTO_RUN  = 2'd1,
      OP_AUTO_HOLD = 2'd2
   } op_t;

   // Power-on table contents; the 4-bit seeds are zero-extended or truncated
   // (LSBs kept) to the entry width, and entries past 3 start at zero.
   function automatic entry_t default_entry(input int idx);
      logic [3:0] seed;
      case (idx)
         1:       seed = 4'b0011;
         2:       seed = 4'b1100;
         3:       seed = 4'b1001;
         default: seed = 4'b0000;
      endcase
      return entry_t'(seed);
   endfunction

   entry_t            tbl_q [N_ENT];
   entry_t            tbl_d [N_ENT];
   logic [SEL_W-1:0]  code_q,    code_d;
   entry_t            pattern_q, pattern_d;
   logic              step_q,    step_d;
   logic [DIV_W-1:0]  presc_q,   presc_d;

   op_t               op;
   logic              step_due;

   // Classify the current edge: manual select, free-running auto, or frozen auto.
   always_comb begin
      op = OP_MANUAL;
      if (mode) begin
         op = hold ? OP_AUTO_HOLD : OP_AUTO_RUN;
      end
   end

   // A step is due once the prescaler has reached the period; using >= means
   // shrinking div below the running count steps at the very next edge.
   assign step_due = (presc_q >= div);

   // Table write port: the new contents are visible to the readout this edge.
   always_comb begin
      tbl_d = tbl_q;
      if (wr_en) begin
         tbl_d[wr_addr] = wr_data;
      end
   end

   // Code and prescaler sequencing for manual, auto-run and auto-hold.
   always_comb begin
      code_d  = code_q;
      presc_d = presc_q;
      step_d  = 1'b0;
      case (op)
         OP_MANUAL: begin
            // Manual follows sel directly; the prescaler parks at zero so a
            // later switch to auto waits a full period before the first step.
            code_d  = sel;
            presc_d = '0;
         end
         OP_AUTO_RUN: begin
            if (step_due) begin
               code_d  = code_q + SEL_W'(1);
               presc_d = '0;
               step_d  = 1'b1;
            end else begin
               // Only reached while presc_q < div, so this never wraps.
               presc_d = presc_q + DIV_W'(1);
            end
         end
         OP_AUTO_HOLD: begin
            code_d  = code_q;
            presc_d = presc_q;
         end
         default: begin
            code_d  = code_q;
            presc_d = presc_q;
         end
      endcase
   end

   // Pattern readout uses the post-write table so a write to the next code
   // appears on pattern_out at the same edge.
   always_comb begin
      pattern_d = tbl_d[code_d];
   end

   // Table storage; reset restores the default contents and drops any writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ENT; i++) begin
            tbl_q[i] <= default_entry(i);
         end
      end else begin
         for (int i = 0; i < N_ENT; i++) begin
            tbl_q[i] <= tbl_d[i];
         end
      end
   end

   // Registered code, pattern, step pulse and prescaler.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q    <= '0;
         pattern_q <= '0;
         step_q    <= 1'b0;
         presc_q   <= '0;
      end else begin
         code_q    <= code_d;
         pattern_q <= pattern_d;
         step_q    <= step_d;
         presc_q   <= presc_d;
      end
   end

   assign code_out    = code_q;
   assign pattern_out = pattern_q;
   assign step        = step_q;

endmodule
